// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, instruction fetch handshake and instruction register for the NN CPU
module instr_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [15:0]      imem_rdata,
    input  logic             pc_en,
    input  logic             stall,
    output logic             instr_valid,
    output logic [3:0]       opcode,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [15:0]      imm,
    output logic [PC_W-1:0]  pc_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic             instr_valid_q, instr_valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Next-state logic: fetch handshake, retire/halt decision, PC and counter updates
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        retired_d     = retired_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_d          = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                // stall outranks pc_en: the instruction stays presented untouched
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    if (pc_en) begin
                        pc_d = pc_q + PC_W'(1);
                        if (retired_q != {CNT_W{1'b1}}) begin
                            retired_d = retired_q + CNT_W'(1);
                        end
                        state_d = FETCH;
                    end else begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = ir_q[15:12];
    assign rd          = ir_q[11:8];
    assign rs          = ir_q[7:4];
    assign rt          = ir_q[3:0];
    assign imm         = {{12{ir_q[3]}}, ir_q[3:0]};
    assign pc_out      = pc_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam int PC_W  = 2;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_valid;
    logic [15:0]      imem_rdata;
    logic             pc_en;
    logic             stall;
    logic             instr_valid;
    logic [3:0]       opcode;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [3:0]       rt;
    logic [15:0]      imm;
    logic [PC_W-1:0]  pc_out;
    logic             halted;
    logic [CNT_W-1:0] retired;

    logic        mem_en;
    logic        man_valid;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [15:0] mem [4];
    int          lat;
    int          wait_cnt;
    int          n_chk;
    int          n_pass;

    assign imem_valid = mem_en ? resp_valid : man_valid;
    assign imem_rdata = resp_data;

    instr_fetch #(
        .PC_W     (PC_W),
        .RESET_PC (2'd0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .pc_en       (pc_en),
        .stall       (stall),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .pc_out      (pc_out),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory responder: lat idle request cycles, then a one-cycle valid pulse
    initial begin
        resp_valid = 1'b0;
        resp_data  = 16'h0000;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (mem_en && imem_req) begin
                if (wait_cnt >= lat) begin
                    resp_valid = 1'b1;
                    resp_data  = mem[imem_addr];
                    wait_cnt   = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pc_en     = 1'b1;
        stall     = 1'b0;
        man_valid = 1'b0;
        mem_en    = 1'b1;
        lat       = 0;
        mem[0]    = 16'h1123;
        mem[1]    = 16'h2456;
        mem[2]    = 16'h3A5F;
        mem[3]    = 16'h0000;

        repeat (2) step();
        chk("rst_iv",      32'(instr_valid), 0);
        chk("rst_halted",  32'(halted), 0);
        chk("rst_req",     32'(imem_req), 0);
        chk("rst_addr",    32'(imem_addr), 0);
        chk("rst_pc",      32'(pc_out), 0);
        chk("rst_opcode",  32'(opcode), 0);
        chk("rst_retired", 32'(retired), 0);

        rst_n = 1'b1;
        step();
        chk("idle_req", 32'(imem_req), 0);

        // zero-wait fetch of two instructions
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f0_req",  32'(imem_req), 1);
        chk("f0_addr", 32'(imem_addr), 0);
        chk("f0_iv",   32'(instr_valid), 0);
        step();
        chk("d0_iv",   32'(instr_valid), 1);
        chk("d0_op",   32'(opcode), 1);
        chk("d0_rd",   32'(rd), 1);
        chk("d0_rs",   32'(rs), 2);
        chk("d0_rt",   32'(rt), 3);
        chk("d0_imm",  32'(imm), 32'h0003);
        chk("d0_pc",   32'(pc_out), 0);
        chk("d0_req",  32'(imem_req), 0);
        step();
        chk("f1_iv",   32'(instr_valid), 0);
        chk("f1_ret",  32'(retired), 1);
        chk("f1_addr", 32'(imem_addr), 1);
        step();
        chk("d1_iv",   32'(instr_valid), 1);
        chk("d1_op",   32'(opcode), 2);
        chk("d1_pc",   32'(pc_out), 1);

        // three-cycle fetch latency
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lat_req",  32'(imem_req), 1);
            chk("lat_addr", 32'(imem_addr), 2);
            chk("lat_iv",   32'(instr_valid), 0);
        end
        chk("lat_ret", 32'(retired), 2);
        step();
        chk("d2_iv",  32'(instr_valid), 1);
        chk("d2_op",  32'(opcode), 3);
        chk("d2_rd",  32'(rd), 32'hA);
        chk("d2_rs",  32'(rs), 5);
        chk("d2_rt",  32'(rt), 32'hF);
        chk("d2_imm", 32'(imm), 32'hFFFF);
        chk("d2_pc",  32'(pc_out), 2);

        // stall for four edges holds everything
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stl_iv",  32'(instr_valid), 1);
            chk("stl_pc",  32'(pc_out), 2);
            chk("stl_op",  32'(opcode), 3);
            chk("stl_ret", 32'(retired), 2);
            chk("stl_req", 32'(imem_req), 0);
        end
        stall = 1'b0;
        lat   = 0;
        step();
        chk("unstl_iv",   32'(instr_valid), 0);
        chk("unstl_ret",  32'(retired), 3);
        chk("unstl_addr", 32'(imem_addr), 3);
        step();
        chk("d3_pc", 32'(pc_out), 3);
        chk("d3_op", 32'(opcode), 0);

        // PC wraps 3 -> 0
        step();
        chk("wrap_addr", 32'(imem_addr), 0);
        chk("wrap_ret",  32'(retired), 4);
        step();
        chk("wrap_pc", 32'(pc_out), 0);
        chk("wrap_op", 32'(opcode), 1);
        mem[0] = 16'hB000;

        // retire until the counter saturates at 7
        repeat (6) step();
        chk("sat_pre", 32'(retired), 7);
        step();
        chk("sat_ret",  32'(retired), 7);
        chk("sat_addr", 32'(imem_addr), 0);
        step();
        chk("hlt_iv", 32'(instr_valid), 1);
        chk("hlt_op", 32'(opcode), 32'hB);

        // HALT: pc_en low
        pc_en = 1'b0;
        step();
        chk("h_iv",     32'(instr_valid), 0);
        chk("h_halted", 32'(halted), 1);
        chk("h_req",    32'(imem_req), 0);
        chk("h_op",     32'(opcode), 32'hB);
        chk("h_pc",     32'(pc_out), 0);
        chk("h_ret",    32'(retired), 7);
        start     = 1'b1;
        mem_en    = 1'b0;
        man_valid = 1'b1;
        step();
        start     = 1'b0;
        man_valid = 1'b0;
        step();
        chk("h2_halted", 32'(halted), 1);
        chk("h2_iv",     32'(instr_valid), 0);
        chk("h2_req",    32'(imem_req), 0);
        chk("h2_op",     32'(opcode), 32'hB);

        // reset leaves HALTED
        rst_n = 1'b0;
        pc_en = 1'b1;
        step();
        chk("r2_halted", 32'(halted), 0);
        chk("r2_pc",     32'(pc_out), 0);
        chk("r2_op",     32'(opcode), 0);
        chk("r2_ret",    32'(retired), 0);
        chk("r2_req",    32'(imem_req), 0);

        // imem_valid in IDLE is ignored
        rst_n     = 1'b1;
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        step();
        chk("idlev_iv",  32'(instr_valid), 0);
        chk("idlev_op",  32'(opcode), 0);
        chk("idlev_req", 32'(imem_req), 0);

        // reset mid-fetch, late valid ignored
        mem[0] = 16'h1123;
        mem_en = 1'b1;
        lat    = 5;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("mf_req", 32'(imem_req), 1);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        mem_en    = 1'b0;
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        chk("mf_iv",  32'(instr_valid), 0);
        chk("mf_op",  32'(opcode), 0);
        chk("mf_req", 32'(imem_req), 0);
        step();
        chk("mf2_iv",  32'(instr_valid), 0);
        chk("mf2_req", 32'(imem_req), 0);
        chk("mf2_op",  32'(opcode), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the opcode decoder (control unit) in the NN CPU.
- Holds the PC and fetches 16-bit instructions from instruction memory over a req/valid handshake.
- Latches each instruction in an instruction register and presents the split fields (opcode to the control unit; register/immediate fields to the register file and ALU).
- Advances or freezes the PC based on the control unit's PCEn, so HALT (opcode 4'b1011) stops fetching.

Parameters:
- PC_W, 8, PC and instruction-memory address width (word addressed).
- RESET_PC, 0, PC value loaded at reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- imem_req  output  1  fetch request, held high while waiting.
- imem_addr  output  PC_W  fetch address (current PC).
- imem_valid  input  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word.
- pc_en  input  1  PCEn from the control unit for the presented opcode.
- stall  input  1  downstream busy; hold the current instruction.
- instr_valid  output  1  fields below are valid.
- opcode  output  4  instr[15:12], to the control unit.
- rd  output  4  instr[11:8].
- rs  output  4  instr[7:4].
- rt  output  4  instr[3:0].
- imm  output  16  instr[3:0] sign-extended.
- pc_out  output  PC_W  PC of the presented instruction.
- halted  output  1  HALT retired; fetch stopped.
- retired  output  CNT_W  count of instructions retired with pc_en=1.

Behaviour:
- Reset (rst_n=0 at an edge, from any state, including mid-fetch):
  - State IDLE; PC=RESET_PC; IR=16'h0000 (so opcode=NOP); retired=0.
  - instr_valid=0, halted=0, imem_req=0.
  - imem_addr=pc_out=RESET_PC.
  - Instruction memory shares rst_n and discards any outstanding request. Any imem_valid seen in IDLE or HALTED is ignored.
- FSM states: IDLE, FETCH, DECODE, HALTED.
- IDLE:
  - imem_req=0.
  - start=1 -> FETCH next cycle.
  - Otherwise stay.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until imem_valid.
  - imem_valid=1 -> IR<=imem_rdata, instr_valid<=1, go to DECODE.
  - Zero-wait memory is legal: imem_valid in the first FETCH cycle gives instr_valid on the next edge.
- DECODE:
  - imem_req=0. Fields and pc_out are combinational from IR/PC and stable all the time instr_valid=1.
  - stall=1: hold everything. stall has priority over pc_en.
  - stall=0 and pc_en=1: retire. PC<=PC+1, wrapping from 2^PC_W-1 to 0. retired<=retired+1, saturating at all-ones. instr_valid<=0. Go to FETCH.
  - stall=0 and pc_en=0: HALT. PC holds, retired holds, instr_valid<=0, halted<=1. Go to HALTED.
- HALTED:
  - Terminal until rst_n=0. start is ignored. halted stays 1.
  - IR and pc_out retain the HALT instruction and its PC.
- Throughput and latency:
  - Minimum 2 cycles per instruction (FETCH and DECODE, one each) with zero-wait memory.
  - Start to first instr_valid: 2 cycles minimum.
- start while not in IDLE: ignored.
- pc_en is sampled only in DECODE with stall=0; its value elsewhere is don't-care.

Test Plan:
- Reset, start, zero-wait memory returning 16'h1123 at addr 0 and 16'h2456 at addr 1 -> instr_valid rises 2 cycles after start; opcode=1, rd=1, rs=2, rt=3, imm=16'h0003, pc_out=0. Then opcode=2, pc_out=1. retired=2 after both retire with pc_en=1.
- 3-cycle memory latency: imem_req stays 1 and imem_addr stays constant for 3 cycles; no instr_valid until 1 cycle after imem_valid.
- instr_valid with stall=1 for 4 cycles, pc_en=1 -> PC, fields and retired frozen 4 cycles; retire on first cycle with stall=0.
- Fetch 16'hB000 with pc_en=0 -> instr_valid falls, halted=1, imem_req stays 0. A further start pulse and an imem_valid pulse cause no change. rst_n=0 restores PC=0 and halted=0.
- PC_W=2, stream of 5 NOPs with pc_en=1 -> pc_out sequence 0,1,2,3,0. imm for rt=4'hF is 16'hFFFF.
- rst_n=0 asserted in FETCH while imem_req=1, imem_valid arrives the next cycle -> state IDLE, instr_valid=0, IR stays 16'h0000.
